stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 42 ++++
 rtl/stopwatch_ctrl_bcd_pair_counter.sv | 42 ++++
 rtl/stopwatch_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the MM:SS stopwatch controller slice:
//   controller state encoding, BCD digit limits, the packed tens:ones pair
//   type and the helper that steps a pair through 00..59.
//   Optional feature macro used by this slice: STOPWATCH_SATURATE_EN
//   (hold at 59:59 in RUN instead of wrapping to 00:00).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    ADJ   = 2'd2
  } state_t;

  localparam logic [2:0] SEC_TENS_MAX = 3'd5;
  localparam logic [3:0] ONES_MAX     = 4'd9;
  localparam logic [2:0] MIN_TENS_MAX = 3'd5;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

  // Next value of a tens:ones BCD pair, wrapping tens_max:9 back to 00.
  function automatic bcd_pair_t bcd_pair_next(input bcd_pair_t cur,
                                              input logic [2:0] tens_max);
    bcd_pair_t nxt;
    nxt = cur;
    if (cur.ones == ONES_MAX) begin
      nxt.ones = 4'd0;
      if (cur.tens == tens_max) begin
        nxt.tens = 3'd0;
      end else begin
        nxt.tens = cur.tens + 3'd1;
      end
    end else begin
      nxt.ones = cur.ones + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_pair_counter.sv
// bcd_pair_counter
//   Two-digit BCD counter (tens:ones) that steps 00..TENS_MAX9 and wraps.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     inc            advance by one this cycle
//     clr            synchronous clear to 00 (wins over inc)
//     hold           suppress the advance even when inc is high
//     tens, ones     registered BCD digits
//     carry_out      inc while the pair sits at its maximum (wrap event);
//                    not masked by hold so the caller can detect saturation
module bcd_pair_counter
  import stopwatch_pkg::*;
#(
  parameter logic [2:0] TENS_MAX = SEC_TENS_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic       hold,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       carry_out
);

  bcd_pair_t value;

  assign carry_out = inc && (value.ones == ONES_MAX) && (value.tens == TENS_MAX);
  assign tens      = value.tens;
  assign ones      = value.ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !hold) begin
      value <= bcd_pair_next(value, TENS_MAX);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Sequencing controller for the 4-digit MM:SS stopwatch. Owns the BCD
//   time registers, derives the 1 Hz count and the adjust-rate increments
//   from clk, and implements run/pause, clear and adj/sel field adjust.
//   Parameters:
//     CLK_DIV_SEC  clk cycles per counted second (>=2)
//     CLK_DIV_ADJ  clk cycles per adjust increment (>=2)
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     pause, clr         debounced synchronous button levels (rising edge acts)
//     adj, sel           adjust mode level; sel=1 seconds, sel=0 minutes
//     m10, m1, s10, s1   registered BCD time digits
//     running            high while in RUN
//     adj_active         high while in ADJ
//   Optional feature: define STOPWATCH_SATURATE_EN to hold at 59:59 in RUN
//   instead of wrapping to 00:00.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV_SEC = 100000000,
  parameter int CLK_DIV_ADJ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  input  logic       clr,
  input  logic       adj,
  input  logic       sel,
  output logic [2:0] m10,
  output logic [3:0] m1,
  output logic [2:0] s10,
  output logic [3:0] s1,
  output logic       running,
  output logic       adj_active
);

  localparam int SEC_W = $clog2(CLK_DIV_SEC);
  localparam int ADJ_W = $clog2(CLK_DIV_ADJ);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_DIV_SEC - 1);
  localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(CLK_DIV_ADJ - 1);

  state_t state, state_next;
  state_t saved, saved_next;

  logic [SEC_W-1:0] sec_cnt;
  logic [ADJ_W-1:0] adj_cnt;
  logic             pause_q, clr_q;

  logic pause_rise, clr_rise;
  logic sec_tc, adj_tc;
  logic run_tick, adj_tick;
  logic sec_inc, min_inc;
  logic sec_carry, min_carry;
  logic sat_hold;

  assign pause_rise = pause & ~pause_q;
  assign clr_rise   = clr & ~clr_q;

  assign sec_tc = (state == RUN) && (sec_cnt == SEC_LAST);
  assign adj_tc = (state == ADJ) && (adj_cnt == ADJ_LAST);

  // A clear in the same cycle as a terminal count drops the increment.
  assign run_tick = sec_tc & ~clr_rise;
  assign adj_tick = adj_tc & ~clr_rise;

  // Seconds carry only ripples into minutes while counting in RUN; in ADJ
  // each field wraps on its own.
  assign sec_inc = run_tick | (adj_tick & sel);
  assign min_inc = (run_tick & sec_carry) | (adj_tick & ~sel);

`ifdef STOPWATCH_SATURATE_EN
  // A minutes carry during a RUN tick only happens at 59:59; freeze both
  // pairs there instead of letting them wrap.
  assign sat_hold = run_tick & min_carry;
`else
  logic unused_min_carry;
  assign unused_min_carry = min_carry;
  assign sat_hold = 1'b0;
`endif

  // Next-state logic. Clear dominates everything and only forces RUN back
  // to PAUSE; adj entry is checked before pause_rise so it wins.
  always_comb begin
    state_next = state;
    saved_next = saved;
    if (clr_rise) begin
      if (state == RUN) begin
        state_next = PAUSE;
      end
    end else begin
      case (state)
        PAUSE: begin
          if (adj) begin
            state_next = ADJ;
            saved_next = PAUSE;
          end else if (pause_rise) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (adj) begin
            state_next = ADJ;
            saved_next = RUN;
          end else if (pause_rise) begin
            state_next = PAUSE;
          end
        end
        ADJ: begin
          if (!adj) begin
            state_next = saved;
          end
        end
        default: begin
          state_next = PAUSE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PAUSE;
      saved      <= PAUSE;
      running    <= 1'b0;
      adj_active <= 1'b0;
      pause_q    <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      state      <= state_next;
      saved      <= saved_next;
      running    <= (state_next == RUN);
      adj_active <= (state_next == ADJ);
      pause_q    <= pause;
      clr_q      <= clr;
    end
  end

  // Prescalers restart on any state change or clear, so a re-entered RUN
  // always waits a full second before its first increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
      adj_cnt <= '0;
    end else if (clr_rise || (state_next != state)) begin
      sec_cnt <= '0;
      adj_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          sec_cnt <= sec_tc ? '0 : sec_cnt + SEC_W'(1);
          adj_cnt <= '0;
        end
        ADJ: begin
          sec_cnt <= '0;
          adj_cnt <= adj_tc ? '0 : adj_cnt + ADJ_W'(1);
        end
        default: begin
          sec_cnt <= '0;
          adj_cnt <= '0;
        end
      endcase
    end
  end

  bcd_pair_counter #(
    .TENS_MAX(SEC_TENS_MAX)
  ) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (sec_inc),
    .clr      (clr_rise),
    .hold     (sat_hold),
    .tens     (s10),
    .ones     (s1),
    .carry_out(sec_carry)
  );

  bcd_pair_counter #(
    .TENS_MAX(MIN_TENS_MAX)
  ) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (min_inc),
    .clr      (clr_rise),
    .hold     (sat_hold),
    .tens     (m10),
    .ones     (m1),
    .carry_out(min_carry)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with CLK_DIV_SEC=4, CLK_DIV_ADJ=2.
//   Directed vector table, hand-written wrap and async-reset sequences, then
//   randomized stimulus compared against a behavioural time/mode model.
module tb_stopwatch_ctrl;

  localparam int SEC_DIV = 4;
  localparam int ADJ_DIV = 2;
`ifdef STOPWATCH_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_ADJ   = 2;

  logic       clk;
  logic       rst_n;
  logic       pause, clr, adj, sel;
  logic [2:0] m10, s10;
  logic [3:0] m1, s1;
  logic       running, adj_active;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .CLK_DIV_SEC(SEC_DIV),
    .CLK_DIV_ADJ(ADJ_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pause     (pause),
    .clr       (clr),
    .adj       (adj),
    .sel       (sel),
    .m10       (m10),
    .m1        (m1),
    .s10       (s10),
    .s1        (s1),
    .running   (running),
    .adj_active(adj_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word {m10,m1,s10,s1,running,adj_active} from MM, SS.
  function automatic logic [15:0] expVal(input int mm, input int ss,
                                         input logic run, input logic adjA);
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), run, adjA};
  endfunction

  // Behavioural model: time kept as plain minutes/seconds integers, one
  // prescaler count of cycles spent in the current mode.
  typedef struct packed {
    int   st;
    int   saved;
    int   pre;
    int   mm;
    int   ss;
    logic pq;
    logic cq;
  } model_t;

  localparam model_t MODEL_RESET = '{st: M_PAUSE, saved: M_PAUSE, pre: 0,
                                     mm: 0, ss: 0, pq: 1'b0, cq: 1'b0};
  model_t mdl;

  function automatic model_t modelStep(input model_t cur, input logic p,
                                       input logic c, input logic a,
                                       input logic s);
    model_t n;
    logic pr, cr, tc;
    int t;
    n = cur;
    pr = p & ~cur.pq;
    cr = c & ~cur.cq;
    n.pq = p;
    n.cq = c;
    if (cr) begin
      n.mm = 0;
      n.ss = 0;
      n.pre = 0;
      if (cur.st == M_RUN) n.st = M_PAUSE;
    end else begin
      tc = 1'b0;
      if (cur.st == M_RUN && cur.pre == SEC_DIV - 1) begin
        tc = 1'b1;
        t = cur.mm * 60 + cur.ss;
        if (!(SAT && t == 3599)) t = (t + 1) % 3600;
        n.mm = t / 60;
        n.ss = t % 60;
      end
      if (cur.st == M_ADJ && cur.pre == ADJ_DIV - 1) begin
        tc = 1'b1;
        if (s) n.ss = (cur.ss + 1) % 60;
        else   n.mm = (cur.mm + 1) % 60;
      end
      if (cur.st == M_PAUSE) begin
        if (a) begin n.st = M_ADJ; n.saved = M_PAUSE; end
        else if (pr) n.st = M_RUN;
      end else if (cur.st == M_RUN) begin
        if (a) begin n.st = M_ADJ; n.saved = M_RUN; end
        else if (pr) n.st = M_PAUSE;
      end else begin
        if (!a) n.st = cur.saved;
      end
      if (n.st != cur.st || cur.st == M_PAUSE || tc) n.pre = 0;
      else n.pre = cur.pre + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= MODEL_RESET;
    else        mdl <= modelStep(mdl, pause, clr, adj, sel);
  end

  function automatic logic [15:0] modelExp();
    return expVal(mdl.mm, mdl.ss, mdl.st == M_RUN, mdl.st == M_ADJ);
  endfunction

  // Drive inputs at a negedge, let n active edges pass, return at a negedge.
  task automatic applyStimulus(input logic p, input logic c, input logic a,
                               input logic s, input int n);
    pause = p;
    clr   = c;
    adj   = a;
    sel   = s;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {m10, m1, s10, s1, running, adj_active};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got m10=%0d m1=%0d s10=%0d s1=%0d run=%0b adj=%0b, expected m10=%0d m1=%0d s10=%0d s1=%0d run=%0b adj=%0b",
               name, act[15:13], act[12:9], act[8:6], act[5:2], act[1], act[0],
               exp[15:13], exp[12:9], exp[8:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  typedef struct {
    logic p, c, a, s;
    int   n;
    int   mm, ss;
    logic run, adjA;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic p, input logic c, input logic a,
                                 input logic s, input int n, input int mm,
                                 input int ss, input logic run, input logic adjA);
    vec_t v;
    v.p = p; v.c = c; v.a = a; v.s = s; v.n = n;
    v.mm = mm; v.ss = ss; v.run = run; v.adjA = adjA;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pause = 1'b0;
    clr   = 1'b0;
    adj   = 1'b0;
    sel   = 1'b0;

    //      p  c  a  s  n    mm ss run adj
    addVec(1, 0, 0, 0,   1,  0, 0, 1, 0);  // pause_rise -> RUN
    addVec(0, 0, 0, 0,   4,  0, 1, 1, 0);  // first second after 4 clk
    addVec(0, 0, 0, 0, 236,  1, 0, 1, 0);  // 240 clk from entry -> 01:00
    addVec(1, 0, 0, 0,   1,  1, 0, 0, 0);  // pause -> PAUSE
    addVec(0, 0, 1, 1,   1,  1, 0, 0, 1);  // enter ADJ
    addVec(0, 0, 1, 1,   6,  1, 3, 0, 1);  // three seconds increments
    addVec(0, 0, 1, 0,   4,  3, 3, 0, 1);  // two minutes increments
    addVec(0, 0, 0, 0,   1,  3, 3, 0, 0);  // back to saved PAUSE
    addVec(0, 0, 0, 0,   5,  3, 3, 0, 0);  // frozen
    addVec(1, 0, 0, 0,   1,  3, 3, 1, 0);  // RUN
    addVec(0, 0, 0, 0,   2,  3, 3, 1, 0);
    addVec(0, 0, 1, 1,   1,  3, 3, 0, 1);  // ADJ from RUN, no tick
    addVec(0, 0, 1, 1,   2,  3, 4, 0, 1);
    addVec(0, 0, 0, 0,   1,  3, 4, 1, 0);  // back to saved RUN
    addVec(0, 0, 0, 0,   3,  3, 4, 1, 0);  // full second wait
    addVec(0, 0, 0, 0,   1,  3, 5, 1, 0);
    addVec(0, 0, 0, 0,   3,  3, 5, 1, 0);  // prescaler at terminal
    addVec(1, 1, 0, 0,   1,  0, 0, 0, 0);  // clr+pause+tc: clear, PAUSE
    addVec(1, 1, 0, 0,   3,  0, 0, 0, 0);  // held levels: no new edges
    addVec(0, 0, 0, 0,   1,  0, 0, 0, 0);
    addVec(0, 0, 1, 1,   1,  0, 0, 0, 1);
    addVec(0, 0, 1, 1,   2,  0, 1, 0, 1);
    addVec(0, 1, 1, 1,   1,  0, 0, 0, 1);  // clear inside ADJ keeps ADJ
    addVec(0, 0, 1, 0,   2,  1, 0, 0, 1);
    addVec(0, 0, 0, 0,   1,  1, 0, 0, 0);
    addVec(1, 0, 1, 1,   1,  1, 0, 0, 1);  // adj entry beats pause_rise
    addVec(0, 0, 0, 0,   1,  1, 0, 0, 0);
    addVec(0, 0, 1, 1,   1,  1, 0, 0, 1);
    addVec(1, 0, 1, 1,   1,  1, 0, 0, 1);  // pause_rise ignored in ADJ
    addVec(0, 0, 1, 1,   1,  1, 1, 0, 1);
    addVec(0, 0, 0, 0,   1,  1, 1, 0, 0);
    addVec(1, 0, 0, 0,   1,  1, 1, 1, 0);
    addVec(0, 0, 0, 0,   3,  1, 1, 1, 0);
    addVec(1, 0, 0, 0,   1,  1, 2, 0, 0);  // tc with pause_rise still counts

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", expVal(0, 0, 1'b0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_release", expVal(0, 0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].p, vecs[i].c, vecs[i].a, vecs[i].s, vecs[i].n);
      checkOutput($sformatf("vec%0d", i),
                  expVal(vecs[i].mm, vecs[i].ss, vecs[i].run, vecs[i].adjA));
    end

    // Preload 59:58 through ADJ, check minute wrap without carry, then run
    // across the 59:59 boundary.
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("wrap_clr", expVal(0, 0, 1'b0, 1'b0));
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 118);
    checkOutput("adj_min59", expVal(59, 0, 1'b0, 1'b1));
    applyStimulus(0, 0, 1, 1, 116);
    checkOutput("adj_sec58", expVal(59, 58, 1'b0, 1'b1));
    applyStimulus(0, 0, 1, 0, 2);
    checkOutput("adj_min_wrap", expVal(0, 58, 1'b0, 1'b1));
    applyStimulus(0, 0, 1, 0, 118);
    checkOutput("adj_min_back", expVal(59, 58, 1'b0, 1'b1));
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("adj_exit", expVal(59, 58, 1'b0, 1'b0));
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("wrap_run", expVal(59, 58, 1'b1, 1'b0));
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("at_5959", expVal(59, 59, 1'b1, 1'b0));
    applyStimulus(0, 0, 0, 0, 4);
    if (SAT) checkOutput("sat_hold", expVal(59, 59, 1'b1, 1'b0));
    else     checkOutput("wrap_0000", expVal(0, 0, 1'b1, 1'b0));
    applyStimulus(0, 0, 0, 0, 4);
    if (SAT) checkOutput("sat_hold2", expVal(59, 59, 1'b1, 1'b0));
    else     checkOutput("wrap_0001", expVal(0, 1, 1'b1, 1'b0));

    // Asynchronous reset in the middle of a count, checked before any edge.
    applyStimulus(0, 0, 0, 0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", expVal(0, 0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("after_reset", expVal(0, 0, 1'b0, 1'b0));

    // Randomized stimulus against the behavioural model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) pause = ~pause;
      clr = ($urandom_range(39) == 0);
      if ($urandom_range(24) == 0) adj = ~adj;
      if ($urandom_range(3) == 0) sel = ~sel;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("rand%0d", i), modelExp());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
